// File: rtl/machine_ctrl.sv
// machine_ctrl: 8-phase instruction sequencer driving fetch, ALU, accumulator, memory and PC strobes
module machine_ctrl #(
    parameter bit HALT_STICKY = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       load_ir,
    output logic       inc_pc,
    output logic       load_pc,
    output logic       rd,
    output logic       wr,
    output logic       datactl_ena,
    output logic       alu_ena,
    output logic       load_acc,
    output logic       halt
);
    typedef enum logic [3:0] {IDLE, S0, S1, S2, S3, S4, S5, S6, S7, HALTED} state_t;
    localparam logic [2:0] OP_HLT = 3'd0, OP_SKZ = 3'd1, OP_LDA = 3'd5, OP_STO = 3'd6, OP_JMP = 3'd7;
    state_t     state, state_n;
    logic [2:0] op_q, op_n;
    logic       z_q, z_n;
    logic       alu_cls, fetch, mid, load_ir_n, inc_pc_n, load_pc_n, rd_n, wr_n, dctl_n, alu_ena_n, load_acc_n, halt_n;
    // Next-state sequencing; ena only matters at instruction boundaries
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = ena ? S0 : IDLE;
            S0:      state_n = S1;
            S1:      state_n = S2;
            S2:      state_n = S3;
            S3:      state_n = (op_q == OP_HLT && HALT_STICKY) ? HALTED : S4;
            S4:      state_n = S5;
            S5:      state_n = S6;
            S6:      state_n = S7;
            S7:      state_n = ena ? S0 : IDLE;
            HALTED:  state_n = HALTED;
            default: state_n = IDLE;
        endcase
    end
    // Outputs are decoded from the upcoming state and the opcode/zero that will be latched, then registered
    always_comb begin
        op_n       = (state == S2) ? opcode : op_q;
        z_n        = (state == S2) ? zero : z_q;
        alu_cls    = (op_n >= 3'd2) && (op_n <= OP_LDA);
        fetch      = (state_n == S0) || (state_n == S1);
        mid        = (state_n == S4) || (state_n == S5) || (state_n == S6);
        load_ir_n  = fetch;
        inc_pc_n   = fetch || ((state_n == S6 || state_n == S7) && op_n == OP_SKZ && z_n);
        load_pc_n  = (state_n == S4 || state_n == S5) && op_n == OP_JMP;
        rd_n       = fetch || (mid && alu_cls);
        wr_n       = (state_n == S5) && op_n == OP_STO;
        dctl_n     = mid && op_n == OP_STO;
        alu_ena_n  = (state_n == S4) && alu_cls;
        load_acc_n = (state_n == S5) && alu_cls;
        halt_n     = (state_n == HALTED) || (state_n == S3 && op_n == OP_HLT);
    end
    // State, latched decode inputs and registered strobes; reset aborts everything at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            op_q        <= '0;
            z_q         <= 1'b0;
            load_ir     <= 1'b0;
            inc_pc      <= 1'b0;
            load_pc     <= 1'b0;
            rd          <= 1'b0;
            wr          <= 1'b0;
            datactl_ena <= 1'b0;
            alu_ena     <= 1'b0;
            load_acc    <= 1'b0;
            halt        <= 1'b0;
        end else begin
            state       <= state_n;
            op_q        <= op_n;
            z_q         <= z_n;
            load_ir     <= load_ir_n;
            inc_pc      <= inc_pc_n;
            load_pc     <= load_pc_n;
            rd          <= rd_n;
            wr          <= wr_n;
            datactl_ena <= dctl_n;
            alu_ena     <= alu_ena_n;
            load_acc    <= load_acc_n;
            halt        <= halt_n;
        end
    end
endmodule

// File: tb/tb_machine_ctrl.sv
// tb_machine_ctrl: table-driven check of the instruction sequencer, sticky and pulsed halt variants
module tb_machine_ctrl;
    logic clk = 1'b0, rst_n = 1'b1, ena = 1'b0, zero = 1'b0;
    logic [2:0] opcode = 3'd0;
    logic [8:0] o1, o0;
    int checks = 0, errors = 0;
    // bit order: load_ir inc_pc load_pc rd wr datactl_ena alu_ena load_acc halt
    localparam logic [8:0] F = 9'b110100000, N = 9'b000000000, H = 9'b000000001;
    localparam logic [8:0] A4 = 9'b000100100, A5 = 9'b000100010, A6 = 9'b000100000;
    localparam logic [8:0] T4 = 9'b000001000, T5 = 9'b000011000, J = 9'b001000000, K = 9'b010000000;
    typedef struct packed {
        logic [2:0]      op;
        logic            z;
        logic [7:0][8:0] e;
    } vec_t;
    vec_t vt [8];

    always #5 clk = ~clk;

    machine_ctrl u_st (
        .clk(clk), .rst_n(rst_n), .ena(ena), .opcode(opcode), .zero(zero),
        .load_ir(o1[8]), .inc_pc(o1[7]), .load_pc(o1[6]), .rd(o1[5]), .wr(o1[4]),
        .datactl_ena(o1[3]), .alu_ena(o1[2]), .load_acc(o1[1]), .halt(o1[0])
    );
    machine_ctrl #(.HALT_STICKY(1'b0)) u_ns (
        .clk(clk), .rst_n(rst_n), .ena(ena), .opcode(opcode), .zero(zero),
        .load_ir(o0[8]), .inc_pc(o0[7]), .load_pc(o0[6]), .rd(o0[5]), .wr(o0[4]),
        .datactl_ena(o0[3]), .alu_ena(o0[2]), .load_acc(o0[1]), .halt(o0[0])
    );

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", name, act, exp);
        end
    endtask

    // Runs n phases of table entry i; ena dips mid-instruction and opcode/zero flip after latching
    task automatic run(input int i, input int n);
        opcode = vt[i].op;
        zero   = vt[i].z;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            chk($sformatf("v%0d S%0d sticky", i, k), o1, vt[i].e[k]);
            chk($sformatf("v%0d S%0d pulse", i, k), o0, vt[i].e[k]);
            if (k == 1) ena = 1'b0;
            if (k == 6) ena = 1'b1;
            if (k >= 3) begin
                opcode = ~vt[i].op;
                zero   = ~vt[i].z;
            end
        end
    endtask

    initial begin
        vt[0] = '{op: 3'd2, z: 1'b0, e: {N, A6, A5, A4, N, N, F, F}};
        vt[1] = '{op: 3'd3, z: 1'b1, e: {N, A6, A5, A4, N, N, F, F}};
        vt[2] = '{op: 3'd4, z: 1'b0, e: {N, A6, A5, A4, N, N, F, F}};
        vt[3] = '{op: 3'd5, z: 1'b1, e: {N, A6, A5, A4, N, N, F, F}};
        vt[4] = '{op: 3'd6, z: 1'b0, e: {N, T4, T5, T4, N, N, F, F}};
        vt[5] = '{op: 3'd7, z: 1'b1, e: {N, N, J, J, N, N, F, F}};
        vt[6] = '{op: 3'd1, z: 1'b1, e: {K, K, N, N, N, N, F, F}};
        vt[7] = '{op: 3'd1, z: 1'b0, e: {N, N, N, N, N, N, F, F}};
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset sticky", o1, N);
        chk("reset pulse", o0, N);
        @(negedge clk) rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk($sformatf("idle%0d", c), o1, N);
        end
        ena = 1'b1;
        for (int i = 0; i < 8; i++) run(i, 8);
        ena = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk($sformatf("drop_ena%0d", c), o1, N);
        end
        ena = 1'b1;
        run(4, 6);
        ena = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst sto sticky", o1, N);
        chk("async_rst sto pulse", o0, N);
        @(negedge clk) rst_n = 1'b1;
        run(4, 8);
        opcode = 3'd0;
        zero   = 1'b0;
        ena    = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk($sformatf("hlt S%0d sticky", k), o1, k < 2 ? F : (k == 2 ? N : H));
            chk($sformatf("hlt S%0d pulse", k), o0, k < 2 ? F : (k == 2 ? N : H));
        end
        for (int j = 0; j < 20; j++) begin
            @(posedge clk); #1;
            chk($sformatf("halted%0d", j), o1, H);
            if (j < 4) chk($sformatf("hlt_nop S%0d", j + 4), o0, N);
            if (j == 4) chk("hlt_next S0", o0, F);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst halt", o1, N);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
